// File: rtl/cond_unit_if.sv
// Bundle between the multicycle control FSM and the conditional-execution stage:
// raw enables and flag sources in, committed strobes and architectural flags out.
interface cond_unit_if;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic [3:0] FPUFlags;
  logic       FPUFlagW;
  logic       NextPC;
  logic       Branch;
  logic       RegW;
  logic       MemW;
  logic       FPUW;
  logic       PCWrite;
  logic       RegWrite;
  logic       MemWrite;
  logic       FPUWrite;
  logic [3:0] Flags;
  logic [3:0] FFlags;

  modport master (
    output Cond, ALUFlags, FlagW, FPUFlags, FPUFlagW, NextPC, Branch, RegW, MemW, FPUW,
    input  PCWrite, RegWrite, MemWrite, FPUWrite, Flags, FFlags
  );

  modport slave (
    input  Cond, ALUFlags, FlagW, FPUFlags, FPUFlagW, NextPC, Branch, RegW, MemW, FPUW,
    output PCWrite, RegWrite, MemWrite, FPUWrite, Flags, FFlags
  );
endinterface

// File: rtl/cond_unit.sv
// Conditional-execution stage: holds NZCV and FPU flags, evaluates Cond, and gates the
// FSM's raw enables into committed write strobes using the condition from the previous cycle.
module cond_unit #(
  parameter logic [3:0] FLAGS_RST   = 4'b0000,
  parameter bit         NV_IS_FALSE = 1'b1
) (
  input logic        clk,
  input logic        reset,
  cond_unit_if.slave bus
);

  logic [3:0] flags;
  logic [3:0] fflags;
  logic       cond_ex;
  logic       cond_ex_r;
  logic       cond_load;
  logic       n, z, c, v;

  assign {n, z, c, v} = flags;

  always_comb begin
    cond_ex = 1'b0;
    case (bus.Cond)
      4'b0000: cond_ex = z;
      4'b0001: cond_ex = ~z;
      4'b0010: cond_ex = c;
      4'b0011: cond_ex = ~c;
      4'b0100: cond_ex = n;
      4'b0101: cond_ex = ~n;
      4'b0110: cond_ex = v;
      4'b0111: cond_ex = ~v;
      4'b1000: cond_ex = c & ~z;
      4'b1001: cond_ex = ~c | z;
      4'b1010: cond_ex = (n == v);
      4'b1011: cond_ex = (n != v);
      4'b1100: cond_ex = ~z & (n == v);
      4'b1101: cond_ex = z | (n != v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = ~NV_IS_FALSE;
    endcase
  end

  // A lone RegW (second writeback of a long multiply) keeps the captured condition,
  // so flags written by the first writeback cannot change the outcome of the second.
  assign cond_load = (|bus.FlagW) | bus.FPUFlagW | bus.Branch | bus.MemW | ~bus.RegW;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags     <= FLAGS_RST;
      fflags    <= FLAGS_RST;
      cond_ex_r <= 1'b0;
    end else begin
      if (bus.FlagW[1] & cond_ex) flags[3:2] <= bus.ALUFlags[3:2];
      if (bus.FlagW[0] & cond_ex) flags[1:0] <= bus.ALUFlags[1:0];
      if (bus.FPUFlagW & cond_ex) fflags     <= bus.FPUFlags;
      if (cond_load)              cond_ex_r  <= cond_ex;
    end
  end

  // Strobes are forced low during reset so a raw NextPC cannot leak through.
  assign bus.PCWrite  = ~reset & (bus.NextPC | (bus.Branch & cond_ex_r));
  assign bus.RegWrite = ~reset & bus.RegW & cond_ex_r;
  assign bus.MemWrite = ~reset & bus.MemW & cond_ex_r;
  assign bus.FPUWrite = ~reset & bus.FPUW & cond_ex_r;
  assign bus.Flags    = flags;
  assign bus.FFlags   = fflags;

endmodule

// File: tb/tb_cond_unit.sv
module tb_cond_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;

  cond_unit_if bus();
  cond_unit dut (.clk(clk), .reset(reset), .bus(bus.slave));

  always #5 clk = ~clk;

  // Model state: architectural flags and the condition verdict the write stage will use.
  logic [3:0] m_flags, m_fflags;
  bit         m_verdict;

  function automatic bit passes(input logic [3:0] cc, input logic [3:0] f);
    bit neg, zero, carry, ovf, signed_ge, unsigned_hi;
    neg = f[3]; zero = f[2]; carry = f[1]; ovf = f[0];
    signed_ge   = (neg == ovf);
    unsigned_hi = carry && !zero;
    case (cc)
      0:  return zero;            1:  return !zero;
      2:  return carry;           3:  return !carry;
      4:  return neg;             5:  return !neg;
      6:  return ovf;             7:  return !ovf;
      8:  return unsigned_hi;     9:  return !unsigned_hi;
      10: return signed_ge;       11: return !signed_ge;
      12: return signed_ge && !zero;
      13: return !(signed_ge && !zero);
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_flags <= 4'h0; m_fflags <= 4'h0; m_verdict <= 1'b0;
    end else begin
      if (passes(bus.Cond, m_flags)) begin
        m_flags <= {bus.FlagW[1] ? bus.ALUFlags[3:2] : m_flags[3:2],
                    bus.FlagW[0] ? bus.ALUFlags[1:0] : m_flags[1:0]};
        if (bus.FPUFlagW) m_fflags <= bus.FPUFlags;
      end
      // Only a pure register writeback (no flag/branch/store activity) keeps the old verdict.
      if (!(bus.RegW && bus.FlagW == 2'b00 && !bus.FPUFlagW && !bus.Branch && !bus.MemW))
        m_verdict <= passes(bus.Cond, m_flags);
    end
  end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("pcwrite", 4'(bus.PCWrite),
        4'(!reset && (bus.NextPC || (bus.Branch && m_verdict))));
    chk("regwrite", 4'(bus.RegWrite), 4'(!reset && bus.RegW && m_verdict));
    chk("memwrite", 4'(bus.MemWrite), 4'(!reset && bus.MemW && m_verdict));
    chk("fpuwrite", 4'(bus.FPUWrite), 4'(!reset && bus.FPUW && m_verdict));
    chk("flags", bus.Flags, m_flags);
    chk("fflags", bus.FFlags, m_fflags);
  end

  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic idle(input logic [3:0] cc);
    bus.Cond = cc; bus.ALUFlags = 4'h0; bus.FlagW = 2'b00; bus.FPUFlags = 4'h0;
    bus.FPUFlagW = 1'b0; bus.NextPC = 1'b0; bus.Branch = 1'b0; bus.RegW = 1'b0;
    bus.MemW = 1'b0; bus.FPUW = 1'b0;
  endtask

  task automatic set_flags(input logic [3:0] f);
    idle(4'b1110); bus.FlagW = 2'b11; bus.ALUFlags = f; next();
  endtask

  logic [3:0] pats [4] = '{4'b0100, 4'b1001, 4'b0010, 4'b1100};

  initial begin
    idle(4'b1110);
    bus.NextPC = 1'b1;
    @(negedge clk);
    chk("lit_reset_pc", 4'(bus.PCWrite), 4'h0);
    chk("lit_reset_flags", bus.Flags, 4'h0);
    chk("lit_reset_fflags", bus.FFlags, 4'h0);
    next();
    reset = 1'b0;
    @(negedge clk);
    chk("lit_fetch_pc", 4'(bus.PCWrite), 4'h1);
    next();

    // EQ / NE branch with Z set
    set_flags(4'b0100);
    idle(4'b0000); next();
    bus.Branch = 1'b1;
    @(negedge clk); chk("lit_beq_taken", 4'(bus.PCWrite), 4'h1);
    next();
    idle(4'b0001); next();
    bus.Branch = 1'b1;
    @(negedge clk); chk("lit_bne_not", 4'(bus.PCWrite), 4'h0);
    next();

    // N=V=1 so LT fails
    set_flags(4'b1001);
    chk("lit_flags_1001", bus.Flags, 4'b1001);
    idle(4'b1011); next();
    bus.RegW = 1'b1;
    @(negedge clk); chk("lit_lt_regwrite", 4'(bus.RegWrite), 4'h0);
    next();

    // EQ fails with Z=0: flags must not change, store suppressed
    idle(4'b0000); bus.FlagW = 2'b11; bus.ALUFlags = 4'b1111; next();
    chk("lit_flags_kept", bus.Flags, 4'b1001);
    idle(4'b0000); bus.MemW = 1'b1;
    @(negedge clk); chk("lit_memwrite", 4'(bus.MemWrite), 4'h0);
    next();

    // FPU flags alone
    idle(4'b1110); bus.FPUFlagW = 1'b1; bus.FPUFlags = 4'b0110; next();
    chk("lit_fflags", bus.FFlags, 4'b0110);
    chk("lit_flags_untouched", bus.Flags, 4'b1001);
    idle(4'b1110); bus.FPUW = 1'b1;
    @(negedge clk); chk("lit_fpuwrite", 4'(bus.FPUWrite), 4'h1);
    next();

    // Simultaneous integer and FPU flag writes, partial integer write
    idle(4'b1110); bus.FlagW = 2'b01; bus.ALUFlags = 4'b0110;
    bus.FPUFlagW = 1'b1; bus.FPUFlags = 4'b1001; next();
    chk("lit_partial_flags", bus.Flags, 4'b1010);
    chk("lit_both_fflags", bus.FFlags, 4'b1001);

    // Long multiply: verdict holds across the second writeback even if Cond changes
    idle(4'b1110); next();
    bus.RegW = 1'b1;
    @(negedge clk); chk("lit_long1", 4'(bus.RegWrite), 4'h1);
    next();
    bus.Cond = 4'b1111;
    @(negedge clk); chk("lit_long2", 4'(bus.RegWrite), 4'h1);
    next();

    // Long multiply interrupted by reset in its second cycle
    idle(4'b1110); next();
    bus.RegW = 1'b1; next();
    reset = 1'b1;
    @(negedge clk);
    chk("lit_reset_mid_rw", 4'(bus.RegWrite), 4'h0);
    chk("lit_reset_mid_flags", bus.Flags, 4'h0);
    next();
    reset = 1'b0;
    idle(4'b1110); next();

    // Sweep every condition code over several flag patterns via a branch
    foreach (pats[p]) begin
      set_flags(pats[p]);
      for (int cc = 0; cc < 16; cc++) begin
        idle(4'(cc)); next();
        bus.Branch = 1'b1; next();
      end
    end

    idle(4'b1110); next();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
